// File: rtl/seg_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_capture_if
// Description : Bundle for the seven-segment capture block.
//               Carries the multiplexed display pins and the recovered frame.
//               seg   - segment lines, active-low, bit0=a .. bit6=g
//               an    - digit enables, active-low, one bit per digit
//               value - last good frame, digit k in value[4k+3:4k]
//               valid - one-cycle pulse when value updates
//               err   - one-cycle pulse on a bad or timed-out frame
//               bad   - per-digit error mask, held until the next event
//               The master side drives the pins; the slave side (the capture
//               block) drives the recovered results.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] value;
    logic              valid;
    logic              err;
    logic [NDIG-1:0]   bad;

    modport master (
        output seg,
        output an,
        input  value,
        input  valid,
        input  err,
        input  bad
    );

    modport slave (
        input  seg,
        input  an,
        output value,
        output valid,
        output err,
        output bad
    );
endinterface
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_capture
// Description : Recovers hex digits from a multiplexed active-low seven-segment
//               bus. A digit is accepted after STABLE_CYC identical samples
//               during a single-digit dwell; a frame is published once every
//               digit has been seen, or flagged if any digit was undecodable
//               or the frame did not complete within TIMEOUT cycles.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - seg_capture_if slave (seg/an in, value/valid/err/bad out)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    seg_capture_if.slave    bus
);

    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_stable   = CW'(STABLE_CYC);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] c_tmr_one  = TW'(1);

    // Input stage
    logic [6:0]        r_seg;
    logic [NDIG-1:0]   r_an;

    // Stability tracking
    logic [6:0]        r_pseg;
    logic [KW-1:0]     r_pk;
    logic              r_pdwell;
    logic [CW-1:0]     r_cnt;

    // Frame assembly
    logic [NDIG-1:0]   r_seen;
    logic [NDIG-1:0]   r_fbad;
    logic [4*NDIG-1:0] r_shadow;
    logic [TW-1:0]     r_tmr;

    // Registered outputs
    logic [4*NDIG-1:0] r_value;
    logic              r_valid;
    logic              r_err;
    logic [NDIG-1:0]   r_bad;

    // Combinational
    logic [NDIG-1:0]   w_sel;
    logic              w_dwell;
    logic [KW-1:0]     w_k;
    logic              w_ok;
    logic [3:0]        w_nib;
    logic              w_same;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_acc;
    logic [NDIG-1:0]   w_seen_n;
    logic [NDIG-1:0]   w_fbad_n;
    logic [4*NDIG-1:0] w_shadow_n;
    logic              w_done;
    logic              w_tmo;

    // A dwell is exactly one enable low; x & (x-1) == 0 tests for one-hot.
    assign w_sel   = ~r_an;
    assign w_dwell = (w_sel != '0) && ((w_sel & (w_sel - NDIG'(1))) == '0);

    always_comb begin
        w_k = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_sel[i]) w_k = KW'(i);
        end
    end

    // Inverse of the nibble-to-segment table; anything else is undecodable.
    always_comb begin
        w_ok  = 1'b1;
        w_nib = 4'h0;
        case (r_seg)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_ok  = 1'b0;
        endcase
    end

    // Counter restarts at 1 whenever the dwell begins or the digit/pattern moves.
    assign w_same = r_pdwell && (r_seg == r_pseg) && (w_k == r_pk);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_dwell) begin
            w_cnt_nxt = '0;
        end else if (!w_same) begin
            w_cnt_nxt = c_cnt_one;
        end else if (r_cnt != c_stable) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
        end
    end

    // Saturation means the transition into c_stable happens once per dwell.
    assign w_acc = (w_cnt_nxt == c_stable) && (r_cnt != c_stable);

    always_comb begin
        w_seen_n   = r_seen;
        w_fbad_n   = r_fbad;
        w_shadow_n = r_shadow;
        if (w_acc) begin
            w_seen_n[w_k] = 1'b1;
            if (w_ok) begin
                w_shadow_n[{w_k, 2'b00} +: 4] = w_nib;
                w_fbad_n[w_k]                 = 1'b0;
            end else begin
                w_fbad_n[w_k] = 1'b1;
            end
        end
    end

    assign w_done = &w_seen_n;
    // Completion takes priority over a timeout landing in the same cycle.
    assign w_tmo  = !w_done && (r_seen != '0) && (r_tmr == c_tmo_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= '0;
            r_an     <= '0;
            r_pseg   <= '0;
            r_pk     <= '0;
            r_pdwell <= 1'b0;
            r_cnt    <= '0;
            r_seen   <= '0;
            r_fbad   <= '0;
            r_shadow <= '0;
            r_tmr    <= '0;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_bad    <= '0;
        end else begin
            r_seg    <= bus.seg;
            r_an     <= bus.an;
            r_pseg   <= r_seg;
            r_pk     <= w_k;
            r_pdwell <= w_dwell;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_n;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;

            if (w_done) begin
                if (w_fbad_n == '0) begin
                    r_value <= w_shadow_n;
                    r_valid <= 1'b1;
                    r_bad   <= '0;
                end else begin
                    r_err   <= 1'b1;
                    r_bad   <= w_fbad_n;
                end
                r_seen <= '0;
                r_fbad <= '0;
                r_tmr  <= '0;
            end else if (w_tmo) begin
                r_err  <= 1'b1;
                r_bad  <= w_fbad_n | ~w_seen_n;
                r_seen <= '0;
                r_fbad <= '0;
                r_tmr  <= '0;
            end else begin
                r_seen <= w_seen_n;
                r_fbad <= w_fbad_n;
                // The accept cycle itself counts as the first timed cycle.
                if (r_seen == '0) begin
                    r_tmr <= w_acc ? c_tmr_one : '0;
                end else begin
                    r_tmr <= r_tmr + c_tmr_one;
                end
            end
        end
    end

    assign bus.value = r_value;
    assign bus.valid = r_valid;
    assign bus.err   = r_err;
    assign bus.bad   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_capture
// Description : Directed self-checking bench for seg_capture (NDIG=4,
//               STABLE_CYC=4, TIMEOUT=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_capture;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_capture_if #(.NDIG(4)) bus ();

    seg_capture #(
        .NDIG       (4),
        .STABLE_CYC (4),
        .TIMEOUT    (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] codes [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (bus.valid) n_valid <= n_valid + 1;
        if (bus.err) n_err <= n_err + 1;
        if (bus.valid && bus.err) n_both <= n_both + 1;
    end

    task automatic drive(input int k, input logic [6:0] code, input int n);
        logic [3:0] a;
        a = 4'b1111;
        a[k] = 1'b0;
        repeat (n) begin
            @(negedge clk);
            bus.an  = a;
            bus.seg = code;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.an  = 4'b1111;
            bus.seg = 7'b1111111;
        end
    endtask

    task automatic scan(input logic [6:0] c0, input logic [6:0] c1,
                        input logic [6:0] c2, input logic [6:0] c3);
        drive(0, c0, 8);
        drive(1, c1, 8);
        drive(2, c2, 8);
        drive(3, c3, 8);
    endtask

    task automatic test_reset();
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (bus.value !== 16'h0) begin fails++; $display("FAIL reset_value got=%h exp=%h", bus.value, 16'h0); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        tests++; if (bus.bad !== 4'h0) begin fails++; $display("FAIL reset_bad got=%b exp=0000", bus.bad); end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        scan(codes[1], codes[2], codes[3], codes[4]);
        idle(4);
        #1;
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL good_valid_count got=%0d exp=1", n_valid - v0); end
        tests++; if (n_err - e0 !== 0) begin fails++; $display("FAIL good_err_count got=%0d exp=0", n_err - e0); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL good_value got=%h exp=4321", bus.value); end
        tests++; if (bus.bad !== 4'b0000) begin fails++; $display("FAIL good_bad got=%b exp=0000", bus.bad); end
    endtask

    task automatic test_blank_digit();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        scan(codes[1], codes[2], 7'b1111111, codes[4]);
        idle(4);
        #1;
        tests++; if (n_err - e0 !== 1) begin fails++; $display("FAIL blank_err_count got=%0d exp=1", n_err - e0); end
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL blank_valid_count got=%0d exp=0", n_valid - v0); end
        tests++; if (bus.bad !== 4'b0100) begin fails++; $display("FAIL blank_bad got=%b exp=0100", bus.bad); end
        tests++; if (bus.value !== 16'h4321) begin fails++; $display("FAIL blank_value got=%h exp=4321", bus.value); end
    endtask

    task automatic test_unstable();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(0, codes[8], 2);
        drive(0, codes[0], 3);
        idle(70);
        #1;
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL unstable_valid_count got=%0d exp=0", n_valid - v0); end
        tests++; if (n_err - e0 !== 0) begin fails++; $display("FAIL unstable_err_count got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_multi_enable();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        repeat (10) begin
            @(negedge clk);
            bus.an  = 4'b1100;
            bus.seg = codes[5];
        end
        idle(70);
        #1;
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL multi_valid_count got=%0d exp=0", n_valid - v0); end
        tests++; if (n_err - e0 !== 0) begin fails++; $display("FAIL multi_err_count got=%0d exp=0", n_err - e0); end
    endtask

    // Digit 0 driven from negedge 0 is accepted in cycle 4, so the timeout
    // error is visible 64 cycles later, at negedge 68.
    task automatic test_timeout();
        int first;
        int v0;
        logic [3:0] bad_at;
        first  = -1;
        bad_at = 4'hx;
        v0     = n_valid;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.err === 1'b1 && first < 0) begin
                first  = i;
                bad_at = bus.bad;
            end
            if (i < 8) begin
                bus.an = 4'b1110; bus.seg = codes[7];
            end else if (i < 16) begin
                bus.an = 4'b1101; bus.seg = codes[9];
            end else begin
                bus.an = 4'b1111; bus.seg = 7'b1111111;
            end
        end
        #1;
        tests++; if (first !== 68) begin fails++; $display("FAIL timeout_cycle got=%0d exp=68", first); end
        tests++; if (bad_at !== 4'b1100) begin fails++; $display("FAIL timeout_bad got=%b exp=1100", bad_at); end
        tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL timeout_valid_count got=%0d exp=0", n_valid - v0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        drive(0, codes[1], 8);
        drive(1, codes[2], 8);
        drive(2, codes[3], 8);
        drive(3, codes[4], 2);
        rst_n = 1'b0;
        #1;
        tests++; if (bus.value !== 16'h0) begin fails++; $display("FAIL midrst_value got=%h exp=0000", bus.value); end
        tests++; if (bus.bad !== 4'b0000) begin fails++; $display("FAIL midrst_bad got=%b exp=0000", bus.bad); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL midrst_err got=%b exp=0", bus.err); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        v0 = n_valid;
        scan(codes[15], codes[14], codes[13], codes[12]);
        idle(4);
        #1;
        tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL midrst_valid_count got=%0d exp=1", n_valid - v0); end
        tests++; if (bus.value !== 16'hCDEF) begin fails++; $display("FAIL midrst_scan_value got=%h exp=CDEF", bus.value); end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        test_reset();
        test_good_frame();
        test_blank_digit();
        test_unstable();
        test_multi_enable();
        test_timeout();
        test_reset_mid_frame();
        tests++; if (n_both !== 0) begin fails++; $display("FAIL valid_err_overlap got=%0d exp=0", n_both); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Reads a multiplexed, active-low 7-segment display bus (segments plus per-digit enables) and recovers the hex value shown, digit by digit.
- Inverse of the team's nibble-to-segment decoder; used for display loopback checking and for reading external seven-segment panels.
- Each digit must hold a stable pattern before it is accepted. A complete frame is published as one word with a valid pulse. Undecodable or missing digits raise an error pulse with a per-digit mask.

Parameters:
NDIG, 4, number of multiplexed digits
STABLE_CYC, 4, consecutive identical samples required to accept a digit (>=2)
TIMEOUT, 64, cycles allowed from first accepted digit to frame completion

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment lines, active-low, bit0=a .. bit6=g
an  input  NDIG  digit enables, active-low, an[k]=0 selects digit k
value  output  4*NDIG  last good frame, digit k in value[4k+3:4k]
valid  output  1  one-cycle pulse when value updates
err  output  1  one-cycle pulse on a bad or timed-out frame
bad  output  NDIG  digit error mask, held until the next valid/err event

Behaviour:
- Reset (async, rst_n=0): value=0, valid=0, err=0, bad=0; all internal state cleared: input regs, stability counter, seen/bad flags, shadow, timer. Reset mid-frame discards the partial frame.
- Input stage: seg and an are registered once (s_seg, s_an) and all logic uses the registered copies.
- Dwell: a dwell exists when s_an has exactly one bit low (digit k). All-high or multiple-low s_an means no dwell; the counter clears and nothing is accepted.
- Stability counter:
  - Loads 1 on the first cycle of a dwell, or whenever s_seg or k differs from the previous cycle.
  - Increments while s_seg and k are unchanged.
  - Saturates at STABLE_CYC.
- Accept: the counter reaching STABLE_CYC accepts digit k exactly once per dwell, and seen[k] is set.
  - If s_seg matches one of the 16 codes, shadow[k] = nibble.
  - Otherwise (including blank 1111111), fbad[k] is set.
  - Re-accepting an already-seen digit in the same frame overwrites it; the latest result wins and clears or sets fbad[k] accordingly.
- Code table (0..F): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Frame completion, evaluated on next-state seen:
  - When seen is all ones and fbad=0: value<=shadow (including the digit accepted this cycle), valid=1 for one cycle, bad<=0.
  - When seen is all ones and fbad!=0: err=1 for one cycle, bad<=fbad, value unchanged.
  - In either case seen, fbad and the timer clear.
- Latency: pins stable from cycle t → accepted in cycle t+STABLE_CYC → valid/err high in cycle t+STABLE_CYC+1 if that digit completes the frame.
- Timeout:
  - The timer starts on the first accept of a frame and counts cycles while the frame is incomplete.
  - On reaching TIMEOUT: err=1, bad<=fbad | ~seen, frame cleared.
  - If completion and timeout occur in the same cycle, completion wins.
- valid and err are never high together. No internal state advances except on a clock edge or async reset.

Test Plan:
- Reset; drive digits 0..3 with codes for 1,2,3,4, each for 8 cycles, in scan order → exactly one valid pulse, value=16'h4321, err=0, bad=0.
- Same scan, but digit 2 shows 1111111 → err pulse, bad=4'b0100, value stays 16'h4321, no valid.
- Digit 0 shows 8 for 2 cycles, then 0 for 3 cycles, then an all high → nothing accepted (counter restarted); no valid/err within 64 cycles.
- an=4'b1100 (two digits low) for 10 cycles with code 5 → ignored, no accept, no timer start.
- Accept digits 0,1 only, then an all high for 64 cycles → err at cycle 64 after the first accept, bad=4'b1100.
- Assert rst_n=0 mid-frame after 3 digits accepted → outputs 0 immediately; a subsequent full scan of F,E,D,C → valid, value=16'hCDEF.
